// File: rtl/gf_mult_pkg.sv
// Shared encodings for the sequential integer / GF(2) multiplier.
// Mode constants and FSM state type.
package gf_mult_pkg;

  localparam logic [1:0] MODE_INT   = 2'd0;
  localparam logic [1:0] MODE_CLMUL = 2'd1;
  localparam logic [1:0] MODE_GF    = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_REDUCE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gf_mult_step.sv
// One multiply iteration: add or XOR operand A into the accumulator
// window aligned at the current bit of B, with carry out.
module gf_mult_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] win,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  en,
  input  logic                  carryless,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry
);

  always_comb begin
    sum   = win;
    carry = 1'b0;
    if (en) begin
      if (carryless) begin
        sum = win ^ a;
      end else begin
        {carry, sum} = {1'b0, win} + {1'b0, a};
      end
    end
  end

endmodule

// File: rtl/gf_int_mult_seq.sv
// Sequential shift-and-add multiplier: unsigned integer, carry-less,
// and GF(2^m) modular product with bit-serial reduction.
module gf_int_mult_seq
  import gf_mult_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int WW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_start,
  input  logic                    in_abort,
  input  logic [1:0]              in_mode,
  input  logic [WW-1:0]           in_width,
  input  logic [DATA_WIDTH-1:0]   in_mult_a,
  input  logic [DATA_WIDTH-1:0]   in_mult_b,
  input  logic [DATA_WIDTH:0]     in_poly,
  output logic                    out_busy,
  output logic                    out_valid,
  output logic                    out_error,
  output logic [2*DATA_WIDTH-1:0] out_mult_result
);

  localparam int DW  = DATA_WIDTH;
  localparam int DW2 = 2 * DATA_WIDTH;
  localparam logic [WW-1:0] WMAX = WW'(DATA_WIDTH);

  state_t          state_q, state_d;
  logic [1:0]      mode_q;
  logic [WW-1:0]   m_q;
  logic [WW-1:0]   cnt_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW:0]     poly_q;
  logic [DW2-1:0]  acc_q;
  logic [DW2-1:0]  res_q;
  logic            err_q;

  logic            bad_req;
  logic [DW-1:0]   op_mask;
  logic [DW:0]     poly_mask;
  logic [DW-1:0]   win;
  logic [DW-1:0]   step_sum;
  logic            step_carry;
  logic [DW2-1:0]  acc_mul;
  logic            mult_last;
  logic            red_hit;
  logic [WW-1:0]   red_sh;
  logic [DW2-1:0]  acc_red;
  logic            red_last;
  logic [WW:0]     res_len;
  logic [DW2-1:0]  res_mask;

  assign bad_req = (in_mode == MODE_RSVD)
                 || (in_width < WW'(2))
                 || (in_width > WMAX);

  assign op_mask   = (DW'(1) << in_width) - DW'(1);
  assign poly_mask = ((DW+1)'(1) << (in_width + WW'(1)))
                   - (DW+1)'(1);

  // Window of the accumulator starting at bit i of the partial product
  assign win = DW'(acc_q >> cnt_q);

  gf_mult_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .win       (win),
    .a         (a_q),
    .en        (b_q[0]),
    .carryless (mode_q != MODE_INT),
    .sum       (step_sum),
    .carry     (step_carry)
  );

  // Bits above i+DW are still zero, so the carry lands in bit i+DW
  assign acc_mul = (acc_q & ~(DW2'({(DW+1){1'b1}}) << cnt_q))
                 | (DW2'({step_carry, step_sum}) << cnt_q);

  assign mult_last = (cnt_q == m_q - WW'(1));

  assign red_hit  = |(acc_q & (DW2'(1) << cnt_q));
  assign red_sh   = cnt_q - m_q;
  assign acc_red  = red_hit ? (acc_q ^ (DW2'(poly_q) << red_sh))
                            : acc_q;
  assign red_last = (cnt_q == m_q);

  always_comb begin
    res_len = {1'b0, m_q};
    case (mode_q)
      MODE_INT:   res_len = {m_q, 1'b0};
      MODE_CLMUL: res_len = {m_q, 1'b0} - (WW+1)'(1);
      default:    res_len = {1'b0, m_q};
    endcase
  end

  assign res_mask = (DW2'(1) << res_len) - DW2'(1);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (in_start) begin
          state_d = bad_req ? ST_DONE : ST_MULT;
        end
      end
      (state_q == ST_MULT): begin
        if (in_abort) begin
          state_d = ST_IDLE;
        end else if (mult_last) begin
          state_d = (mode_q == MODE_GF) ? ST_REDUCE : ST_DONE;
        end
      end
      (state_q == ST_REDUCE): begin
        if (in_abort) begin
          state_d = ST_IDLE;
        end else if (red_last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      poly_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_start) begin
            mode_q <= in_mode;
            m_q    <= in_width;
            a_q    <= in_mult_a & op_mask;
            b_q    <= in_mult_b & op_mask;
            poly_q <= in_poly & poly_mask;
            acc_q  <= '0;
            cnt_q  <= '0;
            err_q  <= bad_req;
            if (bad_req) begin
              res_q <= '0;
            end
          end
        end
        ST_MULT: begin
          if (!in_abort) begin
            acc_q <= acc_mul;
            b_q   <= b_q >> 1;
            if (!mult_last) begin
              cnt_q <= cnt_q + WW'(1);
            end else if (mode_q == MODE_GF) begin
              cnt_q <= (m_q << 1) - WW'(2);
            end else begin
              res_q <= acc_mul & res_mask;
            end
          end
        end
        ST_REDUCE: begin
          if (!in_abort) begin
            acc_q <= acc_red;
            cnt_q <= cnt_q - WW'(1);
            if (red_last) begin
              res_q <= acc_red & res_mask;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_busy        = (state_q == ST_MULT) || (state_q == ST_REDUCE);
  assign out_valid       = (state_q == ST_DONE);
  assign out_error       = (state_q == ST_DONE) && err_q;
  assign out_mult_result = res_q;

endmodule

// File: tb/tb_gf_int_mult_seq.sv
// Scoreboard bench for gf_int_mult_seq: directed vectors, abort,
// ignored starts and asynchronous reset.
module tb_gf_int_mult_seq;

  localparam int DW = 32;
  localparam int WW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_start;
  logic          in_abort;
  logic [1:0]    in_mode;
  logic [WW-1:0] in_width;
  logic [DW-1:0] in_mult_a;
  logic [DW-1:0] in_mult_b;
  logic [DW:0]   in_poly;
  logic          out_busy;
  logic          out_valid;
  logic          out_error;
  logic [2*DW-1:0] out_mult_result;

  gf_int_mult_seq #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_start        (in_start),
    .in_abort        (in_abort),
    .in_mode         (in_mode),
    .in_width        (in_width),
    .in_mult_a       (in_mult_a),
    .in_mult_b       (in_mult_b),
    .in_poly         (in_poly),
    .out_busy        (out_busy),
    .out_valid       (out_valid),
    .out_error       (out_error),
    .out_mult_result (out_mult_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          c0;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Independent GF(2^m) model: interleaved shift-and-reduce of A
  function automatic logic [63:0] gf_ref(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [32:0] poly,
                                         input int m);
    logic [64:0] aa;
    logic [63:0] r;
    aa = 65'(a);
    r  = '0;
    for (int i = 0; i < m; i++) begin
      if (b[i]) r = r ^ aa[63:0];
      aa = aa << 1;
      if (aa[m]) aa = aa ^ 65'(poly);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected 0 at cycle %0d",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_result"}, out_mult_result, e.res);
        check({e.name, "_error"}, 64'(out_error), 64'(e.err));
        check({e.name, "_latency"}, 64'(cyc - e.c0), 64'(e.lat));
      end
    end
  end

  task automatic run(input string nm, input logic [1:0] mode,
                     input int w, input logic [31:0] a,
                     input logic [31:0] b, input logic [32:0] poly,
                     input logic [63:0] r, input logic err,
                     input int lat, input bit stray);
    exp_t e;
    @(negedge clk);
    in_mode   = mode;
    in_width  = WW'(w);
    in_mult_a = a;
    in_mult_b = b;
    in_poly   = poly;
    e.res  = r;
    e.err  = err;
    e.c0   = cyc;
    e.lat  = lat;
    e.name = nm;
    q.push_back(e);
    in_start = 1'b1;
    @(negedge clk);
    in_start  = 1'b0;
    in_mult_a = '1;
    in_mult_b = '1;
    if (stray) begin
      @(negedge clk);
      in_mode  = 2'd0;
      in_width = WW'(5);
      in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0;
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no valid expected valid", nm);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_start  = 1'b0;
    in_abort  = 1'b0;
    in_mode   = '0;
    in_width  = '0;
    in_mult_a = '0;
    in_mult_b = '0;
    in_poly   = '0;
    #12;
    check("reset_busy", 64'(out_busy), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_error", 64'(out_error), 64'd0);
    check("reset_result", out_mult_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("int8_ff", 2'd0, 8, 32'hFF, 32'hFF, 33'h0,
        64'hFE01, 1'b0, 9, 1'b0);
    run("clmul4_stray", 2'd1, 4, 32'hB, 32'h6, 33'h0,
        64'h3A, 1'b0, 5, 1'b1);
    run("aes_57_83", 2'd2, 8, 32'h57, 32'h83, 33'h11B,
        64'hC1, 1'b0, 16, 1'b0);
    run("gf4_m2", 2'd2, 2, 32'h2, 32'h3, 33'h7,
        64'h1, 1'b0, 4, 1'b0);
    run("int32_max", 2'd0, 32, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0,
        64'hFFFFFFFE00000001, 1'b0, 33, 1'b0);
    run("clmul32_max", 2'd1, 32, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0,
        64'h5555555555555555, 1'b0, 33, 1'b0);
    run("gf32_max", 2'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFF,
        33'h100400007,
        gf_ref(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h100400007, 32),
        1'b0, 64, 1'b0);
    run("mode3_err", 2'd3, 8, 32'h12, 32'h34, 33'h0,
        64'h0, 1'b1, 1, 1'b0);
    run("m1_err", 2'd0, 1, 32'h1, 32'h1, 33'h0,
        64'h0, 1'b1, 1, 1'b0);
    run("m33_err", 2'd1, 33, 32'h5, 32'h7, 33'h0,
        64'h0, 1'b1, 1, 1'b0);
    run("int4_masked", 2'd0, 4, 32'hF5, 32'h37, 33'h0,
        64'h23, 1'b0, 5, 1'b0);

    // Abort mid-MULT with a stray start while busy
    @(negedge clk);
    in_mode   = 2'd0;
    in_width  = WW'(8);
    in_mult_a = 32'h3;
    in_mult_b = 32'h5;
    in_start  = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    check("abort_busy_on", 64'(out_busy), 64'd1);
    @(negedge clk);
    in_mult_a = 32'hFF;
    in_start  = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    in_abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_off", 64'(out_busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_held", out_mult_result, 64'h23);
    @(negedge clk);
    in_abort = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle", 64'(out_busy), 64'd0);
    check("abort_held_late", out_mult_result, 64'h23);

    // Asynchronous reset in the middle of MULT
    @(negedge clk);
    in_mode   = 2'd0;
    in_width  = WW'(16);
    in_mult_a = 32'hFFFF;
    in_mult_b = 32'hFFFF;
    in_start  = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(out_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(out_busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_error", 64'(out_error), 64'd0);
    check("rst_result", out_mult_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("int16_post_rst", 2'd0, 16, 32'h1234, 32'h5678, 33'h0,
        64'h06260060, 1'b0, 17, 1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_int_mult_seq.md
GF_INT_MULT_SEQ -- requirements
Module: gf_int_mult_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, maximum operand width in bits (4..64).
REQ-002 SHALL have parameters: none else; WW = $clog2(DATA_WIDTH)+1 is a derived width, not user-settable.
REQ-003 SHALL have ports:
 clk  in  1  single clock, all state on rising edge.
 rst_n  in  1  asynchronous active-low reset.
 in_start  in  1  request; accepted only in IDLE.
 in_abort  in  1  cancels a running operation.
 in_mode  in  2  0=unsigned integer, 1=carry-less GF(2)[x], 2=GF(2^m) modular, 3=reserved.
 in_width  in  WW  operand width m, valid range 2..DATA_WIDTH.
 in_mult_a  in  DATA_WIDTH  operand A; bits >= m ignored.
 in_mult_b  in  DATA_WIDTH  operand B; bits >= m ignored.
 in_poly  in  DATA_WIDTH+1  field polynomial for mode 2 (bit m set, bit 0 set).
 out_busy  out  1  high in MULT/REDUCE.
 out_valid  out  1  one-cycle completion pulse.
 out_error  out  1  qualified by out_valid; illegal mode/width.
 out_mult_result  out  2*DATA_WIDTH  product, held until next accepted start.

Function
REQ-004 SHALL implement FSM IDLE -> MULT -> (REDUCE, mode 2 only) -> DONE -> IDLE; DONE lasts one cycle and drives out_valid.
REQ-005 SHALL latch mode, width, masked operands and poly on the edge where in_start is sampled in IDLE; later input changes have no effect.
REQ-006 SHALL ignore in_start outside IDLE (no queuing, no error).
REQ-007 MULT SHALL process one bit of B per cycle, LSB first, for exactly m cycles: mode 0 adds A<<i with carry; modes 1/2 XOR A<<i.
REQ-008 REDUCE SHALL scan bits 2m-2 down to m, one per cycle (m-1 cycles), XORing poly<<(j-m) when bit j is set.
REQ-009 Latency, start-accept edge k: out_valid at cycle k+m+1 for modes 0/1; k+2m for mode 2.
REQ-010 Result width: mode 0 2m bits; mode 1 2m-1 bits; mode 2 m bits; all upper bits of out_mult_result SHALL be zero.
REQ-011 in_mode=3, m<2 or m>DATA_WIDTH SHALL skip MULT: DONE next cycle with out_error=1, out_mult_result=0.
REQ-012 in_abort in MULT/REDUCE SHALL return to IDLE next edge, no out_valid, out_mult_result unchanged; in_abort in IDLE/DONE is ignored.
REQ-013 in_abort and in_start together in IDLE: start wins.
REQ-014 out_mult_result SHALL update only in DONE; out_busy low in IDLE and DONE.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, out_busy=0, out_valid=0, out_error=0, out_mult_result=0, all internal accumulators/counters 0.
REQ-016 Reset mid-operation SHALL discard the operation; first start after release behaves as from power-up.

Structure
REQ-017 Package gf_mult_pkg SHALL hold the mode encoding constants and the FSM state type.
REQ-018 One combinational sub-module gf_mult_step SHALL compute one MULT iteration (add-or-XOR of shifted A with carry out), parameterised by DATA_WIDTH.
REQ-019 Reduction, FSM and counter SHALL live in the top module; no multiplier primitives or `*` operator.

Verification
REQ-020 Mode 0, m=8, A=0xFF, B=0xFF -> out_valid 9 cycles after start, result 0xFE01, error 0.
REQ-021 Mode 1, m=4, A=0xB, B=0x6 -> result 0x3A after 5 cycles.
REQ-022 Mode 2, m=8, poly=0x11B, A=0x57, B=0x83 -> result 0xC1 after 16 cycles; m=DATA_WIDTH max-value operands vs. reference model.
REQ-023 Mode 3 or m=1 -> out_valid+out_error next cycle after start, result 0.
REQ-024 Start accepted, in_abort at cycle 3 -> no out_valid, busy drops next edge, prior result held; start during busy ignored.
REQ-025 rst_n asserted mid-MULT -> outputs zero immediately (asynchronous); subsequent mode 0 run gives correct result.
